// File: rtl/cpu_req_sequencer.sv
// Scripted CPU request generator: replays a programmed list of READ/WRITE/READ_CHK/NOP
// entries against a cache handshake, counting read-check mismatches and aborting on stalls.
module cpu_req_sequencer #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       prog_en,
    input  logic [$clog2(DEPTH)-1:0]   prog_idx,
    input  logic [1:0]                 prog_op,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [DATA_W-1:0]          prog_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     run_len,
    input  logic                       hit,
    input  logic [DATA_W-1:0]          rData,
    output logic [ADDR_W-1:0]          Address,
    output logic [DATA_W-1:0]          Write_Data,
    output logic                       read,
    output logic                       write,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   cur_idx,
    output logic [ERR_W-1:0]           err_count,
    output logic                       mismatch,
    output logic                       timeout
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned LEN_W   = IDX_W + 1;
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 2);
    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(DEPTH);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RCHK  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               mis_q, mis_d;
    logic               to_q, to_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    // Script storage; deliberately outside the reset domain so scripts survive reset.
    logic [1:0]        mem_op   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [1:0]        ent_op;
    logic [ADDR_W-1:0] ent_addr;
    logic [DATA_W-1:0] ent_data;
    logic              in_run;
    logic              last_ent;
    logic [LEN_W-1:0]  len_clamped;

    assign ent_op      = mem_op[idx_q];
    assign ent_addr    = mem_addr[idx_q];
    assign ent_data    = mem_data[idx_q];
    assign in_run      = (state_q == ST_RUN);
    assign last_ent    = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
    assign len_clamped = (run_len > LEN_MAX) ? LEN_MAX : run_len;

    always_ff @(posedge clock) begin
        if (prog_en && (state_q != ST_RUN)) begin
            mem_op[prog_idx]   <= prog_op;
            mem_addr[prog_idx] <= prog_addr;
            mem_data[prog_idx] <= prog_data;
        end
    end

    // State and run-status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
        mis_d   = mis_q;
        to_d    = to_q;
        stall_d = stall_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_d   = len_clamped;
                    idx_d   = '0;
                    err_d   = '0;
                    mis_d   = 1'b0;
                    to_d    = 1'b0;
                    stall_d = '0;
                    state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if ((ent_op == OP_NOP) || hit) begin
                    stall_d = '0;
                    if ((ent_op == OP_RCHK) && (rData != ent_data)) begin
                        mis_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
                    end
                    if (last_ent) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (TO_EN && (stall_q == STALL_LIM)) begin
                    // Abort in place so cur_idx points at the entry that stalled.
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign read       = in_run && ((ent_op == OP_READ) || (ent_op == OP_RCHK));
    assign write      = in_run && (ent_op == OP_WRITE);
    assign Address    = in_run ? ent_addr : '0;
    assign Write_Data = in_run ? ent_data : '0;
    assign busy       = in_run;
    assign done       = (state_q == ST_DONE);
    assign cur_idx    = idx_q;
    assign err_count  = err_q;
    assign mismatch   = mis_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_cpu_req_sequencer.sv
// Self-checking bench for cpu_req_sequencer: directed script cases plus randomized runs
// with random stalls and ignored-input noise, checked against an entry-level model.
module tb_cpu_req_sequencer;

    localparam int TO    = 4;
    localparam int DEP   = 16;
    localparam int ERR_MAX = 3;

    logic        clock;
    logic        reset;
    logic        prog_en;
    logic [3:0]  prog_idx;
    logic [1:0]  prog_op;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic [4:0]  run_len;
    logic        hit;
    logic [31:0] rData;
    logic [9:0]  Address;
    logic [31:0] Write_Data;
    logic        read;
    logic        write;
    logic        busy;
    logic        done;
    logic [3:0]  cur_idx;
    logic [1:0]  err_count;
    logic        mismatch;
    logic        timeout;

    cpu_req_sequencer #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(DEP), .TIMEOUT(TO), .ERR_W(2)
    ) dut (
        .clock(clock), .reset(reset), .prog_en(prog_en), .prog_idx(prog_idx),
        .prog_op(prog_op), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .run_len(run_len), .hit(hit), .rData(rData),
        .Address(Address), .Write_Data(Write_Data), .read(read), .write(write),
        .busy(busy), .done(done), .cur_idx(cur_idx), .err_count(err_count),
        .mismatch(mismatch), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    // Reference script image and per-entry stimulus plan.
    logic [1:0]  sop   [DEP];
    logic [9:0]  saddr [DEP];
    logic [31:0] sdata [DEP];
    int          k_of  [DEP];
    logic [31:0] rd_of [DEP];

    bit          ps_en;
    int          ps_idx;
    logic [1:0]  ps_op;
    logic [9:0]  ps_addr;
    logic [31:0] ps_data;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic prog(input int idx, input logic [1:0] op, input logic [9:0] a,
                        input logic [31:0] d);
        prog_en   = 1'b1;
        prog_idx  = 4'(idx);
        prog_op   = op;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_en   = 1'b0;
        sop[idx]   = op;
        saddr[idx] = a;
        sdata[idx] = d;
    endtask

    task automatic quiet_inputs();
        prog_en = 1'b0;
        start   = 1'b0;
        run_len = '0;
        hit     = 1'b0;
    endtask

    // Executes one run entry by entry, deciding from the plan when each entry
    // completes or stalls out, and checks every RUN cycle plus the DONE state.
    task automatic run_check(input int len, input bit noise);
        int   eff;
        int   c;
        int   exp_err;
        int   exp_idx;
        bit   exp_mis;
        bit   exp_to;
        bit   aborted;
        logic exp_rd;
        logic exp_wr;
        eff = (len > DEP) ? DEP : len;
        start   = 1'b1;
        run_len = 5'(len);
        if (ps_en) begin
            prog_en   = 1'b1;
            prog_idx  = 4'(ps_idx);
            prog_op   = ps_op;
            prog_addr = ps_addr;
            prog_data = ps_data;
            sop[ps_idx]   = ps_op;
            saddr[ps_idx] = ps_addr;
            sdata[ps_idx] = ps_data;
            ps_en = 1'b0;
        end
        tick();
        quiet_inputs();
        exp_err = 0;
        exp_mis = 1'b0;
        exp_to  = 1'b0;
        aborted = 1'b0;
        exp_idx = (eff == 0) ? 0 : eff - 1;
        for (int i = 0; i < eff && !aborted; i++) begin
            c = 0;
            forever begin
                exp_rd = (sop[i] == 2'd1) || (sop[i] == 2'd3);
                exp_wr = (sop[i] == 2'd2);
                tests++;
                if ({busy, done, read, write, cur_idx, Address, Write_Data} !==
                    {1'b1, 1'b0, exp_rd, exp_wr, 4'(i), saddr[i], sdata[i]}) begin
                    failed++;
                    $display("FAIL run_entry %0d cycle %0d: got b%0b d%0b r%0b w%0b idx%0d a%h wd%h, want b1 d0 r%0b w%0b idx%0d a%h wd%h",
                             i, c, busy, done, read, write, cur_idx, Address, Write_Data,
                             exp_rd, exp_wr, i, saddr[i], sdata[i]);
                end
                if (noise && ($urandom_range(0, 2) == 0)) begin
                    prog_en   = 1'b1;
                    prog_idx  = 4'($urandom);
                    prog_op   = 2'($urandom);
                    prog_addr = 10'($urandom);
                    prog_data = $urandom;
                    start     = 1'b1;
                    run_len   = 5'($urandom);
                end
                if (sop[i] == 2'd0) begin
                    hit   = 1'($urandom);
                    rData = $urandom;
                    tick();
                    quiet_inputs();
                    break;
                end
                if (c == k_of[i]) begin
                    hit   = 1'b1;
                    rData = rd_of[i];
                    if ((sop[i] == 2'd3) && (rd_of[i] != sdata[i])) begin
                        exp_mis = 1'b1;
                        if (exp_err < ERR_MAX) exp_err++;
                    end
                    tick();
                    quiet_inputs();
                    break;
                end
                hit   = 1'b0;
                rData = $urandom;
                tick();
                quiet_inputs();
                if (c == TO - 1) begin
                    exp_to  = 1'b1;
                    exp_idx = i;
                    aborted = 1'b1;
                    break;
                end
                c++;
            end
        end
        tests++;
        if ({busy, done, read, write, Address, Write_Data} !== {4'b0100, 10'd0, 32'd0}) begin
            failed++;
            $display("FAIL done_outputs len %0d: got b%0b d%0b r%0b w%0b a%h wd%h, want b0 d1 r0 w0 a0 wd0",
                     len, busy, done, read, write, Address, Write_Data);
        end
        tests++;
        if ({cur_idx, err_count, mismatch, timeout} !== {4'(exp_idx), 2'(exp_err), exp_mis, exp_to}) begin
            failed++;
            $display("FAIL done_status len %0d: got idx%0d err%0d mis%0b to%0b, want idx%0d err%0d mis%0b to%0b",
                     len, cur_idx, err_count, mismatch, timeout, exp_idx, exp_err, exp_mis, exp_to);
        end
        for (int h = 0; h < 2; h++) begin
            hit   = 1'($urandom);
            rData = $urandom;
            tick();
        end
        hit = 1'b0;
        tests++;
        if ({done, busy, read, write, cur_idx, err_count, mismatch, timeout} !==
            {4'b1000, 4'(exp_idx), 2'(exp_err), exp_mis, exp_to}) begin
            failed++;
            $display("FAIL done_hold len %0d: got d%0b b%0b r%0b w%0b idx%0d err%0d mis%0b to%0b, want d1 b0 r0 w0 idx%0d err%0d mis%0b to%0b",
                     len, done, busy, read, write, cur_idx, err_count, mismatch, timeout,
                     exp_idx, exp_err, exp_mis, exp_to);
        end
    endtask

    task automatic load_basic();
        prog(0, 2'd1, 10'h060, 32'h0);
        prog(1, 2'd2, 10'h040, 32'h123);
        prog(2, 2'd0, 10'h000, 32'h0);
        prog(3, 2'd3, 10'h1D1, 32'h0);
        for (int i = 0; i < DEP; i++) begin
            k_of[i]  = 0;
            rd_of[i] = 32'h0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({busy, done, read, write, cur_idx, err_count, mismatch, timeout, Address, Write_Data} !== '0) begin
            failed++;
            $display("FAIL reset_state: got b%0b d%0b r%0b w%0b idx%0d err%0d mis%0b to%0b a%h wd%h, want all 0",
                     busy, done, read, write, cur_idx, err_count, mismatch, timeout, Address, Write_Data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_script();
        load_basic();
        run_check(4, 1'b0);
    endtask

    task automatic test_chk_mismatch();
        rd_of[3] = 32'h5;
        run_check(4, 1'b0);
        rd_of[3] = 32'h0;
    endtask

    task automatic test_timeout();
        prog(0, 2'd1, 10'h2AA, 32'hDEAD_BEEF);
        prog(1, 2'd2, 10'h155, 32'h0BAD_F00D);
        k_of[0] = 100;
        run_check(2, 1'b0);
        k_of[0] = TO - 1;
        run_check(2, 1'b0);
        k_of[0] = 0;
        k_of[1] = TO - 1;
        run_check(2, 1'b0);
        k_of[1] = TO;
        run_check(2, 1'b0);
        k_of[1] = 0;
    endtask

    task automatic test_zero_len();
        run_check(0, 1'b0);
        start   = 1'b1;
        run_len = 5'd0;
        tick();
        quiet_inputs();
        tests++;
        if ({done, busy, read, write, cur_idx, err_count, mismatch, timeout} !== {4'b1000, 8'd0}) begin
            failed++;
            $display("FAIL zero_len_from_done: got d%0b b%0b r%0b w%0b idx%0d err%0d mis%0b to%0b, want d1 rest 0",
                     done, busy, read, write, cur_idx, err_count, mismatch, timeout);
        end
    endtask

    task automatic test_reset_in_run();
        load_basic();
        start   = 1'b1;
        run_len = 5'd4;
        tick();
        start     = 1'b0;
        hit       = 1'b1;
        rData     = 32'h0;
        prog_en   = 1'b1;
        prog_idx  = 4'd0;
        prog_op   = 2'd2;
        prog_addr = 10'h3FF;
        prog_data = 32'hFFFF_FFFF;
        tick();
        prog_en = 1'b0;
        tick();
        tests++;
        if ({busy, cur_idx} !== {1'b1, 4'd2}) begin
            failed++;
            $display("FAIL pre_reset_idx: got b%0b idx%0d, want b1 idx2", busy, cur_idx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hit   = 1'b0;
        tests++;
        if ({busy, done, read, write, cur_idx, err_count, mismatch, timeout, Address, Write_Data} !== '0) begin
            failed++;
            $display("FAIL reset_in_run: got b%0b d%0b r%0b w%0b idx%0d err%0d mis%0b to%0b a%h wd%h, want all 0",
                     busy, done, read, write, cur_idx, err_count, mismatch, timeout, Address, Write_Data);
        end
        run_check(4, 1'b0);
    endtask

    task automatic test_prog_with_start();
        ps_en   = 1'b1;
        ps_idx  = 0;
        ps_op   = 2'd2;
        ps_addr = 10'h155;
        ps_data = 32'hABCD_1234;
        run_check(1, 1'b0);
    endtask

    task automatic test_random();
        int r;
        for (int iter = 0; iter < 20; iter++) begin
            for (int i = 0; i < DEP; i++) begin
                prog(i, 2'($urandom), 10'($urandom), $urandom);
                r = int'($urandom_range(0, 15));
                k_of[i]  = (r < 14) ? (r % TO) : (TO + r - 14);
                rd_of[i] = ($urandom_range(0, 1) == 1) ? sdata[i]
                           : (sdata[i] ^ (32'd1 << $urandom_range(0, 31)));
            end
            run_check(int'($urandom_range(0, 31)), 1'b1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        prog_en   = 1'b0;
        prog_idx  = '0;
        prog_op   = '0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        run_len   = '0;
        hit       = 1'b0;
        rData     = '0;
        ps_en     = 1'b0;
        ps_idx    = 0;
        ps_op     = '0;
        ps_addr   = '0;
        ps_data   = '0;
        @(negedge clock);
        test_reset();
        test_basic_script();
        test_chk_mismatch();
        test_timeout();
        test_zero_len();
        test_reset_in_run();
        test_prog_with_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
